// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial-pattern detector run controller.
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_detect_ctrl_pattern_match_shift_reg.sv
// Shift register with fill tracking and a length-masked compare against the pattern.
module pattern_match_shift_reg #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               fill_clear,
    input  logic               new_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit_next
);

    logic [MAX_LEN-1:0] sreg, sreg_next, mask;
    logic [LEN_W-1:0]   fill, fill_next;

    // hit_next looks one shift ahead; the caller gates it with shift_en.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sreg_next = {sreg[MAX_LEN-2:0], new_bit};
        fill_next = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit_next = (fill_next >= len) && (((sreg_next ^ pattern) & mask) == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            fill <= '0;
        end else if (clear) begin
            sreg <= '0;
            fill <= '0;
        end else if (shift_en) begin
            sreg <= sreg_next;
            fill <= fill_clear ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config handshake, arm/abort FSM, match counting and registered outputs.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         cfg_overlap,
    output logic                         cfg_err,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         new_bit_valid,
    input  logic                         new_bit,
    output logic                         busy,
    output logic                         detected,
    output logic                         done,
    output logic [CNT_W-1:0]             match_count
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic [CNT_W-1:0]   target_q, count_inc, count_next;
    logic               overlap_q, loaded;
    logic               hs, len_ok, arm, shift_en, hit, det_next, fill_clear;

    assign hs        = cfg_valid & cfg_ready;
    assign len_ok    = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    assign cfg_ready = (state != ARMED);
    assign busy      = (state == ARMED);
    assign done      = (state == DONE);

    pattern_match_shift_reg #(.MAX_LEN(MAX_LEN), .LEN_W(LW)) u_match (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .clear      (arm),
        .fill_clear (fill_clear),
        .new_bit    (new_bit),
        .pattern    (pat_q),
        .len        (len_q),
        .hit_next   (hit)
    );

    always_comb begin
        state_next = state;
        arm        = 1'b0;
        shift_en   = 1'b0;
        count_inc  = (&match_count) ? match_count : match_count + CNT_W'(1);
        count_next = match_count;
        unique case (state)
            IDLE, DONE: begin
                // A handshake owns the cycle; start is only honoured without one.
                if (hs) begin
                    if (len_ok) state_next = IDLE;
                end else if (state == DONE && abort) begin
                    state_next = IDLE;
                end else if (start && loaded) begin
                    state_next = ARMED;
                    arm        = 1'b1;
                    count_next = '0;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (new_bit_valid) begin
                    shift_en = 1'b1;
                    if (hit) begin
                        count_next = count_inc;
                        if (target_q != '0 && count_inc == target_q) state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        det_next   = shift_en & hit;
        fill_clear = det_next & ~overlap_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            detected    <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
            loaded      <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            target_q    <= '0;
            overlap_q   <= 1'b0;
        end else begin
            state       <= state_next;
            detected    <= det_next;
            cfg_err     <= hs & ~len_ok;
            match_count <= count_next;
            if (hs && len_ok) begin
                loaded    <= 1'b1;
                pat_q     <= cfg_pattern;
                len_q     <= cfg_len;
                target_q  <= cfg_target;
                overlap_q <= cfg_overlap;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed scoreboard bench for seq_detect_ctrl against a history-based reference model.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LW      = seq_detect_pkg::LEN_W;

    logic               clk, rst;
    logic               cfg_valid, cfg_ready, cfg_overlap, cfg_err;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic [CNT_W-1:0]   cfg_target, match_count;
    logic               start, abort, new_bit_valid, new_bit;
    logic               busy, detected, done;

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_target    (cfg_target),
        .cfg_overlap   (cfg_overlap),
        .cfg_err       (cfg_err),
        .start         (start),
        .abort         (abort),
        .new_bit_valid (new_bit_valid),
        .new_bit       (new_bit),
        .busy          (busy),
        .detected      (detected),
        .done          (done),
        .match_count   (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       det;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [23:0] stream = 24'b0011_0101_1001_1001_1010_1000;

    // Reference model: 0 idle, 1 armed, 2 done.
    int          m_state = 0;
    bit          m_loaded = 0;
    logic [7:0]  m_pat = '0;
    int          m_len = 0, m_target = 0, m_count = 0, m_avail = 0;
    bit          m_ovl = 0;
    bit          m_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_detected"},  32'(detected),  32'd0);
        check({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
        check({tag, "_count"},     32'(match_count), 32'd0);
    endtask

    task automatic send_bit(input logic b, input logic v, input logic ab);
        exp_t e;
        bit   hit;
        hit = 0;
        new_bit       = b;
        new_bit_valid = v;
        abort         = ab;
        if (m_state == 1) begin
            if (ab) begin
                m_state = 0;
            end else if (v) begin
                m_hist.push_back(b);
                m_avail++;
                if (m_avail >= m_len) begin
                    hit = 1;
                    for (int k = 0; k < m_len; k++)
                        if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) hit = 0;
                end
                if (hit) begin
                    if (m_count < 255) m_count++;
                    if (!m_ovl) m_avail = 0;
                    if (m_target != 0 && m_count == m_target) m_state = 2;
                end
            end
        end else if (m_state == 2 && ab) begin
            m_state = 0;
        end
        e = '{det: hit, cnt: m_count[7:0], busy: (m_state == 1), done: (m_state == 2)};
        sb.push_back(e);
        @(posedge clk); #1;
        new_bit_valid = 1'b0;
        abort         = 1'b0;
        e = sb.pop_front();
        check("detected", 32'(detected),    32'(e.det));
        check("count",    32'(match_count), 32'(e.cnt));
        check("busy",     32'(busy),        32'(e.busy));
        check("done",     32'(done),        32'(e.done));
    endtask

    task automatic configure(input logic [7:0] pat, input int len, input int target,
                             input bit ovl, input bit st);
        bit legal;
        legal       = (len >= 1 && len <= MAX_LEN);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LW'(len);
        cfg_target  = CNT_W'(target);
        cfg_overlap = ovl;
        start       = st;
        if (m_state != 1 && legal) begin
            m_pat = pat; m_len = len; m_target = target; m_ovl = ovl;
            m_loaded = 1; m_state = 0;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 32'(!legal));
        check("cfg_busy",      32'(busy),    32'(m_state == 1));
        @(posedge clk); #1;
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        if (m_state != 1 && m_loaded) begin
            m_state = 1; m_count = 0; m_avail = 0;
            m_hist.delete();
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy",  32'(busy),        32'(m_state == 1));
        check("start_count", 32'(match_count), 32'(m_count));
    endtask

    task automatic run_stream(input bit gaps);
        for (int i = 0; i < 24; i++) begin
            send_bit(stream[23-i], 1'b1, 1'b0);
            if (gaps) send_bit(~stream[23-i], 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        cfg_overlap = 0; start = 0; abort = 0; new_bit_valid = 0; new_bit = 0;
        #2 rst = 1'b0;
        #3 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // start with nothing loaded, then illegal lengths
        do_start();
        configure(8'h00, 0, 0, 1'b1, 1'b0);
        configure(8'hff, MAX_LEN + 1, 0, 1'b1, 1'b0);
        do_start();

        // 110011 overlap, with start in the handshake cycle
        configure(8'b0011_0011, 6, 0, 1'b1, 1'b1);
        do_start();
        run_stream(1'b0);
        check("ovl6_total", 32'(match_count), 32'd2);
        send_bit(1'b0, 1'b0, 1'b1);
        check("abort_hold", 32'(match_count), 32'd2);

        // 110011 non-overlap
        configure(8'b0011_0011, 6, 0, 1'b0, 1'b0);
        do_start();
        run_stream(1'b0);
        check("novl6_total", 32'(match_count), 32'd1);
        send_bit(1'b0, 1'b0, 1'b1);

        // 1010 overlap unlimited
        configure(8'b0000_1010, 4, 0, 1'b1, 1'b0);
        do_start();
        run_stream(1'b0);
        check("ovl4_total", 32'(match_count), 32'd3);
        send_bit(1'b0, 1'b0, 1'b1);

        // 1010 target 2, then rearm from DONE
        configure(8'b0000_1010, 4, 2, 1'b1, 1'b0);
        do_start();
        run_stream(1'b0);
        check("tgt_total", 32'(match_count), 32'd2);
        check("tgt_done",  32'(done), 32'd1);
        do_start();
        check("rearm_count", 32'(match_count), 32'd0);
        send_bit(1'b0, 1'b0, 1'b1);

        // 110011 with idle cycles interleaved
        configure(8'b0011_0011, 6, 0, 1'b1, 1'b0);
        do_start();
        run_stream(1'b1);
        check("gap_total", 32'(match_count), 32'd2);
        send_bit(1'b0, 1'b0, 1'b1);

        // abort on the bit that would complete the second 1010 match
        configure(8'b0000_1010, 4, 0, 1'b1, 1'b0);
        do_start();
        for (int i = 0; i < 19; i++) send_bit(stream[23-i], 1'b1, 1'b0);
        send_bit(stream[23-19], 1'b1, 1'b1);
        check("abort_count", 32'(match_count), 32'd1);
        check("abort_idle",  32'(cfg_ready), 32'd1);
        send_bit(1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-run
        configure(8'b0011_0011, 6, 0, 1'b1, 1'b0);
        do_start();
        for (int i = 0; i < 13; i++) send_bit(stream[23-i], 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        m_state = 0; m_loaded = 0; m_count = 0; m_avail = 0; m_hist.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        do_start();
        configure(8'b0011_0011, 6, 0, 1'b1, 1'b0);
        do_start();
        send_bit(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
